// File: rtl/mul_csa_pipe.sv
// Pipelined carry-save array multiplier, full 2W-bit product.
// Per-transaction unsigned or Baugh-Wooley signed, valid/ready both sides.
module mul_csa_pipe #(
  parameter int W              = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p
);
  localparam int R  = ROWS_PER_STAGE;
  localparam int NS = W / R;
  localparam int PW = 2 * W;

  if (W < 4 || W > 32 || R < 1 || (W % R) != 0) begin : g_bad_param
    $error("mul_csa_pipe: illegal W=%0d ROWS_PER_STAGE=%0d", W, R);
  end

  // Baugh-Wooley constants ride in the initial carry vector
  localparam logic [PW-1:0] BW_K = (PW'(1) << W) | (PW'(1) << (PW - 1));

  function automatic logic [PW-1:0] pp_row(
    input logic [W-1:0] a,
    input logic         bi,
    input logic         sg,
    input int           i
  );
    logic [W-1:0] row;
    logic [W-1:0] inv;
    row = a & {W{bi}};
    if (i == W - 1) inv = {1'b0, {(W-1){1'b1}}};
    else            inv = {1'b1, {(W-1){1'b0}}};
    if (sg) row = row ^ inv;
    return {{W{1'b0}}, row} << i;
  endfunction

  logic          adv;
  logic          out_valid_q;
  logic [PW-1:0] out_p_q;
  logic [PW-1:0] fin_s;
  logic [PW-1:0] fin_c;
  logic          fin_v;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  for (genvar k = 0; k < NS; k++) begin : g_st
    logic [PW-1:0] s_i, c_i, s_d, c_d, s_q, c_q;
    logic [W-1:0]  a_i, b_i;
    logic          sg_i, v_i, v_q;

    if (k == 0) begin : g_head
      assign s_i  = '0;
      assign c_i  = in_signed ? BW_K : '0;
      assign a_i  = in_a;
      assign b_i  = in_b;
      assign sg_i = in_signed;
      assign v_i  = in_valid;
    end else begin : g_link
      assign s_i  = g_st[k-1].s_q;
      assign c_i  = g_st[k-1].c_q;
      assign a_i  = g_st[k-1].g_fwd.a_q;
      assign b_i  = g_st[k-1].g_fwd.b_q;
      assign sg_i = g_st[k-1].g_fwd.sg_q;
      assign v_i  = g_st[k-1].v_q;
    end

    always_comb begin
      logic [W-1:0]  bits;
      logic [PW-1:0] pp;
      logic [PW-1:0] t;
      s_d  = s_i;
      c_d  = c_i;
      bits = b_i;
      pp   = '0;
      t    = '0;
      for (int r = 0; r < R; r++) begin
        pp   = pp_row(a_i, bits[0], sg_i, k * R + r);
        t    = s_d ^ c_d ^ pp;
        c_d  = ((s_d & c_d) | (s_d & pp) | (c_d & pp)) << 1;
        s_d  = t;
        bits = bits >> 1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst)      v_q <= 1'b0;
      else if (adv) v_q <= v_i;
    end

    always_ff @(posedge clk) begin
      if (adv) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    // Only stages feeding another CSA stage need operands
    if (k < NS - 1) begin : g_fwd
      logic [W-1:0] a_q, b_q;
      logic         sg_q;
      always_ff @(posedge clk) begin
        if (adv) begin
          a_q  <= a_i;
          b_q  <= b_i >> R;
          sg_q <= sg_i;
        end
      end
    end

    if (k == NS - 1) begin : g_tail
      assign fin_s = s_q;
      assign fin_c = c_q;
      assign fin_v = v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else if (adv) begin
      out_valid_q <= fin_v;
      out_p_q     <= fin_s + fin_c;
    end
  end

endmodule

// File: tb/tb_mul_csa_pipe.sv
// Self-checking bench for mul_csa_pipe: four parameter sets share stimulus,
// each scored against a plain-arithmetic product model.
module tb_mul_csa_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        sg = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic [3:0]  rdy;
  logic [3:0]  ov;
  logic [15:0] p0;
  logic [31:0] p1;
  logic [15:0] p2;
  logic [15:0] p3;
  logic [31:0] op [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_csa_pipe #(.W(8), .ROWS_PER_STAGE(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(a[7:0]), .in_b(b[7:0]), .in_signed(sg),
    .out_valid(ov[0]), .out_ready(out_ready), .out_p(p0));

  mul_csa_pipe #(.W(16), .ROWS_PER_STAGE(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(a), .in_b(b), .in_signed(sg),
    .out_valid(ov[1]), .out_ready(out_ready), .out_p(p1));

  mul_csa_pipe #(.W(8), .ROWS_PER_STAGE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(a[7:0]), .in_b(b[7:0]), .in_signed(sg),
    .out_valid(ov[2]), .out_ready(out_ready), .out_p(p2));

  mul_csa_pipe #(.W(8), .ROWS_PER_STAGE(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_a(a[7:0]), .in_b(b[7:0]), .in_signed(sg),
    .out_valid(ov[3]), .out_ready(out_ready), .out_p(p3));

  assign op[0] = {16'b0, p0};
  assign op[1] = p1;
  assign op[2] = {16'b0, p2};
  assign op[3] = {16'b0, p3};

  function automatic int wof(input int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic int rof(input int k);
    case (k)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: truncate to w bits, optionally sign-extend, multiply
  function automatic logic [31:0] model(
    input logic [15:0] x, input logic [15:0] y,
    input logic s, input int w);
    logic [63:0]        m;
    logic [63:0]        ux, uy;
    logic signed [63:0] sx, sy, p;
    m  = (64'd1 << w) - 64'd1;
    ux = {48'b0, x} & m;
    uy = {48'b0, y} & m;
    sx = $signed(ux);
    sy = $signed(uy);
    if (s && ((ux >> (w - 1)) & 64'd1) != 0) sx = sx - $signed(64'd1 << w);
    if (s && ((uy >> (w - 1)) & 64'd1) != 0) sy = sy - $signed(64'd1 << w);
    p = sx * sy;
    m = (64'd1 << (2 * w)) - 64'd1;
    return p[31:0] & m[31:0];
  endfunction

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard state
  logic [31:0] fifo [4][64];
  int          wp [4];
  int          rp [4];
  bit          hold_v [4];
  logic [31:0] hold_p [4];
  bit          watch_rst = 1'b0;
  int          ovcnt [4];

  initial begin
    for (int k = 0; k < 4; k++) begin
      wp[k] = 0; rp[k] = 0; hold_v[k] = 1'b0;
      hold_p[k] = '0; ovcnt[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        wp[k] = 0;
        rp[k] = 0;
        hold_v[k] = 1'b0;
      end else begin
        chk(rdy[k] === (!ov[k] || out_ready),
            $sformatf("in_ready%0d", k), 32'(rdy[k]),
            32'(!ov[k] || out_ready));
        if (hold_v[k])
          chk(ov[k] === 1'b1 && op[k] === hold_p[k],
              $sformatf("hold%0d", k), op[k], hold_p[k]);
        if (watch_rst && ov[k]) ovcnt[k]++;
        if (in_valid && rdy[k]) begin
          fifo[k][wp[k] % 64] = model(a, b, sg, wof(k));
          wp[k]++;
        end
        if (ov[k] && out_ready) begin
          chk(rp[k] != wp[k], $sformatf("extra_out%0d", k),
              32'(rp[k]), 32'(wp[k]));
          if (rp[k] != wp[k]) begin
            chk(op[k] === fifo[k][rp[k] % 64], $sformatf("prod%0d", k),
                op[k], fifo[k][rp[k] % 64]);
            rp[k]++;
          end
        end
        hold_v[k] = ov[k] && !out_ready;
        hold_p[k] = op[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 9))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0080;
      4:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic single(input logic [15:0] ta, input logic [15:0] tb,
                        input logic ts, input logic [31:0] l0,
                        input logic [31:0] l1);
    int lat [4];
    step();
    a = ta; b = tb; sg = ts; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (ov[k] && lat[k] == 0) begin
          lat[k] = n;
          if (k == 0) chk(op[0] === l0, "lit8", op[0], l0);
          if (k == 1) chk(op[1] === l1, "lit16", op[1], l1);
        end
      end
    end
    for (int k = 0; k < 4; k++)
      chk(lat[k] == wof(k) / rof(k) + 1, $sformatf("latency%0d", k),
          32'(lat[k]), 32'(wof(k) / rof(k) + 1));
  endtask

  logic [15:0] bb_a [6] = '{16'h00C8, 16'h00C8, 16'hFFFF,
                            16'h0055, 16'hFF80, 16'h1234};
  logic [15:0] bb_b [6] = '{16'h0003, 16'h0003, 16'hFFFF,
                            16'h00AA, 16'h007F, 16'h8765};
  logic        bb_s [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int first, last, cnt;
    logic [31:0] frz;

    @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk(ov[k] === 1'b0, $sformatf("rst_ov%0d", k), 32'(ov[k]), 0);
      chk(op[k] === 32'h0, $sformatf("rst_p%0d", k), op[k], 0);
      chk(rdy[k] === 1'b1, $sformatf("rst_rdy%0d", k), 32'(rdy[k]), 1);
    end
    step();
    rst = 1'b0;

    single(16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 32'h0000FE01);
    single(16'h0000, 16'h00AD, 1'b0, 32'h00000000, 32'h00000000);
    single(16'hFF80, 16'hFF80, 1'b1, 32'h00004000, 32'h00004000);
    single(16'hFFFF, 16'h0001, 1'b1, 32'h0000FFFF, 32'hFFFFFFFF);
    single(16'hFF80, 16'h007F, 1'b1, 32'h0000C080, 32'hFFFFC080);
    single(16'h007F, 16'h007F, 1'b1, 32'h00003F01, 32'h00003F01);
    single(16'hFFFF, 16'hFFFF, 1'b0, 32'h0000FE01, 32'hFFFE0001);
    single(16'h8000, 16'h8000, 1'b1, 32'h00000000, 32'h40000000);

    // Back-to-back burst of six
    step();
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        a = bb_a[i]; b = bb_b[i]; sg = bb_s[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (ov[0]) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
      if (i == 5) begin
        chk(op[0] === 32'h0258, "b2b_uns", op[0], 32'h0258);
        chk(op[1] === 32'h0258, "b2b_w16", op[1], 32'h0258);
      end
      if (i == 6) chk(op[0] === 32'hFF58, "b2b_sig", op[0], 32'hFF58);
      step();
    end
    chk(cnt == 6, "b2b_count", 32'(cnt), 6);
    chk(first == 5 && last == 10, "b2b_gapless",
        32'(last - first), 5);

    // Stall with full pipe
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom); b = 16'($urandom); sg = 1'($urandom);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    frz = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) frz = op[0];
      chk(ov[0] === 1'b1, "stall_ov", 32'(ov[0]), 1);
      chk(rdy[0] === 1'b0, "stall_rdy", 32'(rdy[0]), 0);
      chk(op[0] === frz, "stall_frozen", op[0], frz);
      step();
      a = 16'($urandom); b = 16'($urandom); sg = 1'($urandom);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (15) step();
    for (int k = 0; k < 4; k++)
      chk(rp[k] == wp[k], $sformatf("stall_drain%0d", k),
          32'(wp[k] - rp[k]), 0);

    // Reset with products in flight
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom); sg = 1'($urandom);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk(ov[k] === 1'b0, $sformatf("mid_rst_ov%0d", k), 32'(ov[k]), 0);
      chk(op[k] === 32'h0, $sformatf("mid_rst_p%0d", k), op[k], 0);
      chk(rdy[k] === 1'b1, $sformatf("mid_rst_rdy%0d", k),
          32'(rdy[k]), 1);
    end
    watch_rst = 1'b1;
    repeat (12) @(negedge clk);
    watch_rst = 1'b0;
    for (int k = 0; k < 4; k++)
      chk(ovcnt[k] == 0, $sformatf("stale%0d", k), 32'(ovcnt[k]), 0);

    // Randomized traffic
    for (int i = 0; i < 12000; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a  = pick();
      b  = pick();
      sg = 1'($urandom);
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (15) step();
    for (int k = 0; k < 4; k++)
      chk(rp[k] == wp[k], $sformatf("rand_drain%0d", k),
          32'(wp[k] - rp[k]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
